lsu_mem_sequencer: RTL and testbench

- Multi-cycle controller that sequences every load/store between the execute stage and a variable-latency data-memory port.
- Per operation: accepts the request, checks alignment, generates word address, byte enables and replicated store data, and drives a req/grant/rvalid handshake with a timeout.
- Formats load data (sign- or zero-extended) and stalls the pipeline until the access completes.

---
 rtl/lsu_mem_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_lsu_mem_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_sequencer.sv
// Load/store sequencer: one memory op at a time between execute and a variable-latency
// data port, with alignment checking, lane formatting and a request/response timeout.
module lsu_mem_sequencer #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic [2:0]            LoadStoreControl,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic                  RespValid,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  MisalignErr,
    output logic                  BusErr,
    output logic                  Stall,
    output logic                  MemReq,
    output logic                  MemWe,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic [DATA_WIDTH-1:0] MemWData,
    output logic [3:0]            MemBe,
    input  logic                  MemGnt,
    input  logic                  MemRValid,
    input  logic [DATA_WIDTH-1:0] MemRData
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b011;
    localparam logic [2:0] OP_LHU = 3'b100;
    localparam logic [2:0] OP_SB  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SW  = 3'b111;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} state_t;

    state_t                  state_reg;
    logic [2:0]              op_reg;
    logic [1:0]              offs_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic                    mem_req_reg;
    logic                    mem_we_reg;
    logic [ADDR_WIDTH-1:0]   mem_addr_reg;
    logic [DATA_WIDTH-1:0]   mem_wdata_reg;
    logic [3:0]              mem_be_reg;
    logic                    resp_valid_reg;
    logic [DATA_WIDTH-1:0]   read_data_reg;
    logic                    misalign_reg;
    logic                    bus_err_reg;

    logic                    req_is_store;
    logic                    req_is_byte;
    logic                    req_is_half;
    logic                    req_misaligned;
    logic [3:0]              req_be;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic                    op_is_store;
    logic [DATA_WIDTH-1:0]   load_lane;
    logic [DATA_WIDTH-1:0]   load_data;

    always_comb begin
        req_is_store   = LoadStoreControl inside {OP_SB, OP_SH, OP_SW};
        req_is_byte    = LoadStoreControl inside {OP_LB, OP_LBU, OP_SB};
        req_is_half    = LoadStoreControl inside {OP_LH, OP_LHU, OP_SH};
        req_misaligned = (req_is_half && Address[0]) ||
                         (!req_is_byte && !req_is_half && (Address[1:0] != 2'b00));
    end

    // Per byte lane: loads always fetch the full word; stores replicate the narrow datum
    // across every lane so the enables alone select where it lands.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign req_be[gi] = !req_is_store ? 1'b1 :
                                req_is_byte   ? (Address[1:0] == 2'(gi)) :
                                req_is_half   ? (Address[1] == 1'(gi / 2)) : 1'b1;
            assign req_wdata[gi*8 +: 8] = !req_is_store ? 8'h00 :
                                          req_is_byte   ? WriteData[7:0] :
                                          req_is_half   ? WriteData[(gi % 2)*8 +: 8] :
                                                          WriteData[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        op_is_store = op_reg inside {OP_SB, OP_SH, OP_SW};
        load_lane   = MemRData >> {offs_reg, 3'b000};
        case (op_reg)
            OP_LB:   load_data = {{24{load_lane[7]}}, load_lane[7:0]};
            OP_LBU:  load_data = {24'h0, load_lane[7:0]};
            OP_LH:   load_data = {{16{load_lane[15]}}, load_lane[15:0]};
            OP_LHU:  load_data = {16'h0, load_lane[15:0]};
            default: load_data = load_lane;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            op_reg         <= '0;
            offs_reg       <= '0;
            cnt_reg        <= '0;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            mem_be_reg     <= '0;
            resp_valid_reg <= 1'b0;
            read_data_reg  <= '0;
            misalign_reg   <= 1'b0;
            bus_err_reg    <= 1'b0;
        end else begin
            resp_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (ReqValid) begin
                        op_reg   <= LoadStoreControl;
                        offs_reg <= Address[1:0];
                        cnt_reg  <= '0;
                        if (req_misaligned) begin
                            state_reg      <= ST_RESP;
                            resp_valid_reg <= 1'b1;
                            misalign_reg   <= 1'b1;
                            bus_err_reg    <= 1'b0;
                            read_data_reg  <= '0;
                        end else begin
                            state_reg     <= ST_REQ;
                            mem_req_reg   <= 1'b1;
                            mem_we_reg    <= req_is_store;
                            mem_addr_reg  <= {Address[ADDR_WIDTH-1:2], 2'b00};
                            mem_be_reg    <= req_be;
                            mem_wdata_reg <= req_wdata;
                        end
                    end
                end
                ST_REQ: begin
                    // A grant completes a store outright; a load completes only if the data
                    // arrives with the grant. Completion beats a coincident timeout.
                    if (MemGnt && (op_is_store || MemRValid)) begin
                        state_reg      <= ST_RESP;
                        mem_req_reg    <= 1'b0;
                        resp_valid_reg <= 1'b1;
                        misalign_reg   <= 1'b0;
                        bus_err_reg    <= 1'b0;
                        read_data_reg  <= op_is_store ? '0 : load_data;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg      <= ST_RESP;
                        mem_req_reg    <= 1'b0;
                        resp_valid_reg <= 1'b1;
                        misalign_reg   <= 1'b0;
                        bus_err_reg    <= 1'b1;
                        read_data_reg  <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (MemGnt) begin
                            state_reg   <= ST_WAIT;
                            mem_req_reg <= 1'b0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (MemRValid) begin
                        state_reg      <= ST_RESP;
                        resp_valid_reg <= 1'b1;
                        misalign_reg   <= 1'b0;
                        bus_err_reg    <= 1'b0;
                        read_data_reg  <= load_data;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg      <= ST_RESP;
                        resp_valid_reg <= 1'b1;
                        misalign_reg   <= 1'b0;
                        bus_err_reg    <= 1'b1;
                        read_data_reg  <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_RESP: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign ReqReady    = (state_reg == ST_IDLE);
    assign Stall       = ((state_reg == ST_IDLE) && ReqValid) ||
                         (state_reg == ST_REQ) || (state_reg == ST_WAIT);
    assign RespValid   = resp_valid_reg;
    assign ReadData    = read_data_reg;
    assign MisalignErr = misalign_reg;
    assign BusErr      = bus_err_reg;
    assign MemReq      = mem_req_reg;
    assign MemWe       = mem_we_reg;
    assign MemAddr     = mem_addr_reg;
    assign MemWData    = mem_wdata_reg;
    assign MemBe       = mem_be_reg;

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Bench for lsu_mem_sequencer: directed scenarios plus randomized ops checked against
// a transaction-level model of latency, formatting and error outcome.
module tb_lsu_mem_sequencer;
    localparam int TO = 8;

    logic        clk;
    logic        rst_n;
    logic        ReqValid;
    logic        ReqReady;
    logic [2:0]  LoadStoreControl;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        RespValid;
    logic [31:0] ReadData;
    logic        MisalignErr;
    logic        BusErr;
    logic        Stall;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [3:0]  MemBe;
    logic        MemGnt;
    logic        MemRValid;
    logic [31:0] MemRData;

    lsu_mem_sequencer #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ReqValid(ReqValid), .ReqReady(ReqReady),
        .LoadStoreControl(LoadStoreControl), .Address(Address), .WriteData(WriteData),
        .RespValid(RespValid), .ReadData(ReadData),
        .MisalignErr(MisalignErr), .BusErr(BusErr), .Stall(Stall),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData), .MemBe(MemBe),
        .MemGnt(MemGnt), .MemRValid(MemRValid), .MemRData(MemRData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Observations gathered by run_op
    int          o_lat;
    logic [31:0] o_rdata, o_rdata0, o_addr, o_wdata;
    logic [3:0]  o_be;
    logic        o_we, o_merr, o_berr, o_req_at_resp, o_stall_ok, o_req_seen, o_stable;
    logic        o_ready0, o_rv0;

    // Model predictions
    int          e_lat;
    logic [31:0] e_rdata, e_addr, e_wdata;
    logic [3:0]  e_be;
    logic        e_we, e_merr, e_berr;
    logic [31:0] prev_rdata;

    // g: REQ cycles without grant before the grant; r: cycles from grant to rvalid.
    task automatic model(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] raw, input int g, input int r, input bit no_rv);
        int sz, off, c;
        logic [31:0] lane, b, h;
        off = int'(addr[1:0]);
        sz = (op == 3'd0 || op == 3'd3 || op == 3'd5) ? 1 :
             (op == 3'd1 || op == 3'd4 || op == 3'd6) ? 2 : 4;
        e_we   = (op >= 3'd5);
        e_merr = (off % sz) != 0;
        e_addr = addr - 32'(off);
        e_be   = !e_we ? 4'hF : (sz == 1) ? 4'(1 << off) : (sz == 2) ? ((off >= 2) ? 4'hC : 4'h3) : 4'hF;
        e_wdata = (sz == 1) ? (wd & 32'hFF) * 32'h01010101 :
                  (sz == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
        if (e_merr) begin
            e_lat  = 1;
            e_berr = 1'b0;
        end else begin
            c = e_we ? g + 1 : (no_rv ? 1000 : g + 1 + r);
            e_berr = (c > TO);
            e_lat  = 1 + (e_berr ? TO : c);
        end
        lane = raw >> (8 * off);
        b = lane & 32'hFF;
        h = lane & 32'hFFFF;
        if (e_merr || e_berr || e_we) e_rdata = 32'h0;
        else begin
            case (op)
                3'd0:    e_rdata = (b >= 128) ? b + 32'hFFFFFF00 : b;
                3'd3:    e_rdata = b;
                3'd1:    e_rdata = (h >= 32768) ? h + 32'hFFFF0000 : h;
                3'd4:    e_rdata = h;
                default: e_rdata = raw;
            endcase
        end
    endtask

    // Presents one op at a negedge, then acts as the memory until RespValid (bounded).
    task automatic run_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] raw, input int g, input int r, input bit no_rv);
        int req_idx, gnt_k;
        bit is_st;
        is_st = (op >= 3'd5);
        @(negedge clk);
        o_ready0 = ReqReady;
        o_rv0    = RespValid;
        o_rdata0 = ReadData;
        ReqValid = 1'b1; LoadStoreControl = op; Address = addr; WriteData = wd;
        MemGnt = 1'b0; MemRValid = 1'b0;
        #1;
        o_stall_ok = (Stall === 1'b1);
        o_req_seen = 1'b0; o_stable = 1'b1; o_lat = -1; req_idx = 0; gnt_k = -1;
        o_req_at_resp = 1'b1; o_merr = 1'b0; o_berr = 1'b0; o_rdata = 32'hx;
        for (int k = 1; k <= 40 && o_lat < 0; k++) begin
            @(negedge clk);
            ReqValid = 1'b0; Address = $urandom; WriteData = $urandom; LoadStoreControl = 3'($urandom);
            if (RespValid === 1'b1) begin
                o_lat = k; o_rdata = ReadData; o_merr = MisalignErr; o_berr = BusErr;
                o_req_at_resp = MemReq;
                if (Stall !== 1'b0) o_stall_ok = 1'b0;
                MemGnt = 1'b0; MemRValid = 1'b0; MemRData = $urandom;
            end else begin
                if (Stall !== 1'b1) o_stall_ok = 1'b0;
                if (MemReq === 1'b1) begin
                    req_idx++;
                    if (!o_req_seen) begin
                        o_req_seen = 1'b1; o_addr = MemAddr; o_be = MemBe; o_we = MemWe; o_wdata = MemWData;
                    end else if (MemAddr !== o_addr || MemBe !== o_be || MemWe !== o_we || MemWData !== o_wdata) begin
                        o_stable = 1'b0;
                    end
                end
                MemGnt = (MemReq === 1'b1) && (req_idx == g + 1);
                if (MemGnt && gnt_k < 0) gnt_k = k;
                if (!is_st && gnt_k >= 0 && (k - gnt_k) == r && !no_rv) begin
                    MemRValid = 1'b1; MemRData = raw;
                end else begin
                    // Stray beats before the grant must be ignored by the sequencer.
                    MemRValid = (gnt_k < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                    MemRData  = $urandom;
                end
            end
        end
        MemGnt = 1'b0; MemRValid = 1'b0;
        $display("op=%0d addr=%h wd=%h raw=%h g=%0d r=%0d norv=%0d -> lat=%0d rdata=%h merr=%0d berr=%0d",
                 op, addr, wd, raw, g, r, no_rv, o_lat, o_rdata, o_merr, o_berr);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ReqValid = 1'b0; LoadStoreControl = 3'd0; Address = 32'h0; WriteData = 32'h0;
        MemGnt = 1'b0; MemRValid = 1'b0; MemRData = 32'h0;
        repeat (3) @(negedge clk);
        checks++; if (ReqReady !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ReqReady); end
        checks++; if ({RespValid, MisalignErr, BusErr, Stall, MemReq, MemWe} !== 6'b0) begin errors++; $display("FAIL reset_flags: got %b want 000000", {RespValid, MisalignErr, BusErr, Stall, MemReq, MemWe}); end
        checks++; if ({ReadData, MemAddr, MemWData, MemBe} !== 100'b0) begin errors++; $display("FAIL reset_data: got %h/%h/%h/%h want zeros", ReadData, MemAddr, MemWData, MemBe); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (ReqReady !== 1'b1 || RespValid !== 1'b0) begin errors++; $display("FAIL reset_release: ready=%b rv=%b want 1/0", ReqReady, RespValid); end
        prev_rdata = 32'h0;
    endtask

    task automatic test_lb_sign();
        model(3'd0, 32'h1003, 32'h0, 32'h80FF1234, 0, 1, 1'b0);
        run_op(3'd0, 32'h1003, 32'h0, 32'h80FF1234, 0, 1, 1'b0);
        checks++; if (o_addr !== 32'h1000 || o_be !== 4'hF || o_we !== 1'b0) begin errors++; $display("FAIL lb_req: addr=%h be=%h we=%b want 1000/f/0", o_addr, o_be, o_we); end
        checks++; if (o_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata: got %h want ffffff80", o_rdata); end
        checks++; if (o_lat !== 3) begin errors++; $display("FAIL lb_latency: got %0d want 3", o_lat); end
        checks++; if (o_stall_ok !== 1'b1) begin errors++; $display("FAIL lb_stall: got %b want 1", o_stall_ok); end
        prev_rdata = e_rdata;
    endtask

    task automatic test_misalign();
        run_op(3'd6, 32'h3003, 32'h12345678, 32'h0, 0, 0, 1'b0);
        checks++; if (o_merr !== 1'b1 || o_berr !== 1'b0 || o_lat !== 1) begin errors++; $display("FAIL sh_misalign: merr=%b berr=%b lat=%0d want 1/0/1", o_merr, o_berr, o_lat); end
        checks++; if (o_req_seen !== 1'b0 || o_rdata !== 32'h0) begin errors++; $display("FAIL sh_misalign_noreq: req=%b rdata=%h want 0/0", o_req_seen, o_rdata); end
        run_op(3'd7, 32'h3002, 32'h12345678, 32'h0, 0, 0, 1'b0);
        checks++; if (o_merr !== 1'b1 || o_req_seen !== 1'b0 || o_lat !== 1) begin errors++; $display("FAIL sw_misalign: merr=%b req=%b lat=%0d want 1/0/1", o_merr, o_req_seen, o_lat); end
        prev_rdata = 32'h0;
    endtask

    task automatic test_lh_lhu();
        run_op(3'd4, 32'h2002, 32'h0, 32'h9ABC0000, 0, 0, 1'b0);
        checks++; if (o_rdata !== 32'h00009ABC || o_lat !== 2) begin errors++; $display("FAIL lhu: rdata=%h lat=%0d want 00009abc/2", o_rdata, o_lat); end
        run_op(3'd1, 32'h2002, 32'h0, 32'h9ABC0000, 0, 0, 1'b0);
        checks++; if (o_rdata !== 32'hFFFF9ABC || o_lat !== 2) begin errors++; $display("FAIL lh: rdata=%h lat=%0d want ffff9abc/2", o_rdata, o_lat); end
        prev_rdata = 32'hFFFF9ABC;
    endtask

    task automatic test_sb_stable();
        run_op(3'd5, 32'h3001, 32'h123456AA, 32'h0, 3, 0, 1'b0);
        checks++; if (o_be !== 4'b0010 || o_wdata !== 32'hAAAAAAAA || o_we !== 1'b1) begin errors++; $display("FAIL sb_fields: be=%b wdata=%h we=%b want 0010/aaaaaaaa/1", o_be, o_wdata, o_we); end
        checks++; if (o_stable !== 1'b1 || o_addr !== 32'h3000) begin errors++; $display("FAIL sb_stable: stable=%b addr=%h want 1/3000", o_stable, o_addr); end
        checks++; if (o_lat !== 5 || o_rdata !== 32'h0) begin errors++; $display("FAIL sb_resp: lat=%0d rdata=%h want 5/0", o_lat, o_rdata); end
        prev_rdata = 32'h0;
    endtask

    task automatic test_timeout();
        run_op(3'd2, 32'h4000, 32'h0, 32'h0, 0, 0, 1'b1);
        checks++; if (o_berr !== 1'b1 || o_lat !== TO + 1) begin errors++; $display("FAIL lw_timeout: berr=%b lat=%0d want 1/%0d", o_berr, o_lat, TO + 1); end
        checks++; if (o_rdata !== 32'h0 || o_req_at_resp !== 1'b0) begin errors++; $display("FAIL lw_timeout_data: rdata=%h memreq=%b want 0/0", o_rdata, o_req_at_resp); end
        run_op(3'd7, 32'h4004, 32'hCAFEF00D, 32'h0, TO, 0, 1'b0);
        checks++; if (o_berr !== 1'b1 || o_lat !== TO + 1 || o_req_at_resp !== 1'b0) begin errors++; $display("FAIL sw_timeout: berr=%b lat=%0d memreq=%b want 1/%0d/0", o_berr, o_lat, o_req_at_resp, TO + 1); end
        prev_rdata = 32'h0;
    endtask

    task automatic test_completion_wins();
        run_op(3'd2, 32'h5008, 32'h0, 32'h0BADF00D, 3, 4, 1'b0);
        checks++; if (o_berr !== 1'b0 || o_rdata !== 32'h0BADF00D || o_lat !== TO + 1) begin errors++; $display("FAIL lw_last_cycle: berr=%b rdata=%h lat=%0d want 0/0badf00d/%0d", o_berr, o_rdata, o_lat, TO + 1); end
        run_op(3'd7, 32'h500C, 32'h11223344, 32'h0, TO - 1, 0, 1'b0);
        checks++; if (o_berr !== 1'b0 || o_lat !== TO + 1) begin errors++; $display("FAIL sw_last_cycle: berr=%b lat=%0d want 0/%0d", o_berr, o_lat, TO + 1); end
        prev_rdata = 32'h0;
    endtask

    task automatic test_random_back_to_back(input int n);
        logic [2:0] op;
        logic [31:0] addr, wd, raw;
        int g, r;
        bit no_rv;
        for (int i = 0; i < n; i++) begin
            op = 3'($urandom); addr = $urandom; wd = $urandom; raw = $urandom;
            g = $urandom_range(0, 5); r = $urandom_range(0, 3); no_rv = ($urandom_range(0, 15) == 0);
            model(op, addr, wd, raw, g, r, no_rv);
            run_op(op, addr, wd, raw, g, r, no_rv);
            checks++; if (o_ready0 !== 1'b1 || o_rv0 !== 1'b0) begin errors++; $display("FAIL rnd%0d_idle: ready=%b rv=%b want 1/0", i, o_ready0, o_rv0); end
            checks++; if (o_rdata0 !== prev_rdata) begin errors++; $display("FAIL rnd%0d_hold: got %h want %h", i, o_rdata0, prev_rdata); end
            checks++; if (o_lat !== e_lat) begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, o_lat, e_lat); end
            checks++; if (o_rdata !== e_rdata || o_merr !== e_merr || o_berr !== e_berr) begin errors++; $display("FAIL rnd%0d_resp: rdata=%h merr=%b berr=%b want %h/%b/%b", i, o_rdata, o_merr, o_berr, e_rdata, e_merr, e_berr); end
            checks++; if (o_stall_ok !== 1'b1 || o_req_at_resp !== 1'b0) begin errors++; $display("FAIL rnd%0d_stall: stall_ok=%b memreq=%b want 1/0", i, o_stall_ok, o_req_at_resp); end
            checks++; if (o_req_seen !== !e_merr) begin errors++; $display("FAIL rnd%0d_reqseen: got %b want %b", i, o_req_seen, !e_merr); end
            if (!e_merr) begin
                checks++; if (o_addr !== e_addr || o_be !== e_be || o_we !== e_we || o_stable !== 1'b1) begin errors++; $display("FAIL rnd%0d_req: addr=%h be=%h we=%b stable=%b want %h/%h/%b/1", i, o_addr, o_be, o_we, o_stable, e_addr, e_be, e_we); end
                if (e_we) begin
                    checks++; if (o_wdata !== e_wdata) begin errors++; $display("FAIL rnd%0d_wdata: got %h want %h", i, o_wdata, e_wdata); end
                end
            end
            prev_rdata = e_rdata;
        end
    endtask

    task automatic test_reset_mid();
        bit seen_rv, ready_ok;
        // Reset while requesting: MemReq must fall without waiting for a clock.
        @(negedge clk);
        ReqValid = 1'b1; LoadStoreControl = 3'd7; Address = 32'h6000; WriteData = 32'h5555AAAA;
        @(negedge clk);
        ReqValid = 1'b0;
        checks++; if (MemReq !== 1'b1) begin errors++; $display("FAIL rst_req_pre: memreq=%b want 1", MemReq); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (MemReq !== 1'b0 || ReqReady !== 1'b1) begin errors++; $display("FAIL rst_req_drop: memreq=%b ready=%b want 0/1", MemReq, ReqReady); end
        @(negedge clk);
        rst_n = 1'b1;
        // Reset while waiting for read data, then a stray rvalid afterwards.
        @(negedge clk);
        ReqValid = 1'b1; LoadStoreControl = 3'd2; Address = 32'h7000;
        @(negedge clk);
        ReqValid = 1'b0; MemGnt = 1'b1;
        @(negedge clk);
        MemGnt = 1'b0;
        checks++; if (MemReq !== 1'b0 || Stall !== 1'b1) begin errors++; $display("FAIL rst_wait_pre: memreq=%b stall=%b want 0/1", MemReq, Stall); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ReqReady !== 1'b1 || Stall !== 1'b0) begin errors++; $display("FAIL rst_wait_idle: ready=%b stall=%b want 1/0", ReqReady, Stall); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        MemRValid = 1'b1; MemRData = 32'hDEADBEEF;
        seen_rv = 1'b0; ready_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            MemRValid = 1'b0;
            if (RespValid !== 1'b0) seen_rv = 1'b1;
            if (ReqReady !== 1'b1) ready_ok = 1'b0;
        end
        checks++; if (seen_rv || !ready_ok || ReadData !== 32'h0) begin errors++; $display("FAIL rst_stray_rvalid: rv_seen=%b ready_ok=%b rdata=%h want 0/1/0", seen_rv, ready_ok, ReadData); end
        prev_rdata = 32'h0;
    endtask

    initial begin
        test_reset();
        test_lb_sign();
        test_misalign();
        test_lh_lhu();
        test_sb_stable();
        test_timeout();
        test_completion_wins();
        test_random_back_to_back(60);
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
